design_28_mch: RTL

- Parametrised successor to the two-operand registered datapath block.
- Multi-channel pipelined arithmetic unit with valid/ready handshakes on input and output, a selectable operation per transaction, per-channel accumulators and per-channel sticky overflow flags.
- Sits between the operand source and the result consumer.
- Replaces the fixed single-register capture and start/valid pulse with a backpressure-aware pipeline of configurable depth.

---
 rtl/design_28_mch.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/design_28_mch.sv
// design_28_mch: multi-channel pipelined arithmetic unit.
//
// Each accepted transaction is evaluated when it is accepted (ADD, SUB,
// unsigned MAX, or per-channel accumulate). The result then travels through
// a STAGES-deep register pipeline to the output register. The whole pipe
// freezes while the output holds an untaken result. Each channel has an
// accumulator and a sticky overflow flag. A sticky flag is set when an
// overflowing result for that channel leaves the output.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_ch, op, a, b     transaction payload (b is ignored for ACC)
//   out_valid/out_ready output handshake
//   out_ch, y, ovf      result payload
//   ovf_sticky          per-channel sticky overflow
//   clr_ovf             per-channel sticky clear pulse (a set wins)
//   busy                any pipeline stage holds a valid transaction
module design_28_mch #(
    parameter int unsigned W      = 16,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned STAGES = 2,
    localparam int unsigned CH_W  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic [1:0]      op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch,
    output logic [W-1:0]    y,
    output logic            ovf,
    output logic [N_CH-1:0] ovf_sticky,
    input  logic [N_CH-1:0] clr_ovf,
    output logic            busy
);

    localparam int unsigned LAST  = STAGES - 1;
    localparam int unsigned STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MAX = 2'd2;
    localparam logic [1:0] OP_ACC = 2'd3;

    // Pipeline stage registers; the stage at index LAST is the output register.
    logic            vld_q [STAGES];
    logic            vld_d [STAGES];
    logic [CH_W-1:0] ch_q  [STAGES];
    logic [CH_W-1:0] ch_d  [STAGES];
    logic [W-1:0]    y_q   [STAGES];
    logic [W-1:0]    y_d   [STAGES];
    logic            ovf_q [STAGES];
    logic            ovf_d [STAGES];

    // Per-channel state.
    logic [W-1:0]    acc_q [N_CH];
    logic [W-1:0]    acc_d [N_CH];
    logic [N_CH-1:0] sticky_q;
    logic [N_CH-1:0] sticky_d;

    logic            stall_c;
    logic            accept_c;
    logic [W:0]      ext_c;
    logic [W-1:0]    res_y_c;
    logic            res_ovf_c;
    logic [N_CH-1:0] set_c;

    // Handshake: the pipe moves unless the output holds an untaken result.
    assign out_valid  = vld_q[STG_W'(LAST)];
    assign out_ch     = ch_q[STG_W'(LAST)];
    assign y          = y_q[STG_W'(LAST)];
    assign ovf        = ovf_q[STG_W'(LAST)];
    assign ovf_sticky = sticky_q;
    assign stall_c    = out_valid && !out_ready;
    assign in_ready   = !stall_c && !rst;
    assign accept_c   = in_valid && in_ready;

    // Busy: OR of all stage valid bits.
    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            busy = busy | vld_q[STG_W'(i)];
        end
    end

    // Arithmetic on a W+1-bit intermediate; the top bit is carry or borrow.
    // For MAX the top bit is always 0, so ovf is 0 without extra logic.
    always_comb begin
        ext_c = '0;
        case (op)
            OP_ADD:  ext_c = {1'b0, a} + {1'b0, b};
            OP_SUB:  ext_c = {1'b0, a} - {1'b0, b};
            OP_MAX:  ext_c = (a >= b) ? {1'b0, a} : {1'b0, b};
            OP_ACC:  ext_c = {1'b0, acc_q[in_ch]} + {1'b0, a};
            default: ext_c = '0;
        endcase
        res_y_c   = ext_c[W-1:0];
        res_ovf_c = ext_c[W];
    end

    // Pipeline next state: hold on stall, otherwise shift. A bubble enters
    // stage 0 when nothing is accepted.
    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            vld_d[STG_W'(i)] = vld_q[STG_W'(i)];
            ch_d[STG_W'(i)]  = ch_q[STG_W'(i)];
            y_d[STG_W'(i)]   = y_q[STG_W'(i)];
            ovf_d[STG_W'(i)] = ovf_q[STG_W'(i)];
        end
        if (!stall_c) begin
            vld_d[0] = accept_c;
            ch_d[0]  = in_ch;
            y_d[0]   = res_y_c;
            ovf_d[0] = res_ovf_c;
            for (int unsigned i = 1; i < STAGES; i++) begin
                vld_d[STG_W'(i)] = vld_q[STG_W'(i - 1)];
                ch_d[STG_W'(i)]  = ch_q[STG_W'(i - 1)];
                y_d[STG_W'(i)]   = y_q[STG_W'(i - 1)];
                ovf_d[STG_W'(i)] = ovf_q[STG_W'(i - 1)];
            end
        end
    end

    // Accumulators update on the accepting edge, so a back-to-back ACC on the
    // same channel reads the value that was just written.
    always_comb begin
        acc_d = acc_q;
        if (accept_c && (op == OP_ACC)) begin
            acc_d[in_ch] = res_y_c;
        end
    end

    // Sticky overflow is set when a result transfers at the output. A set
    // overrides a clear that arrives in the same cycle.
    always_comb begin
        set_c = '0;
        if (out_valid && out_ready && ovf) begin
            set_c[out_ch] = 1'b1;
        end
        sticky_d = (sticky_q & ~clr_ovf) | set_c;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                vld_q[STG_W'(i)] <= 1'b0;
                ch_q[STG_W'(i)]  <= '0;
                y_q[STG_W'(i)]   <= '0;
                ovf_q[STG_W'(i)] <= 1'b0;
            end
            for (int unsigned c = 0; c < N_CH; c++) begin
                acc_q[CH_W'(c)] <= '0;
            end
            sticky_q <= '0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                vld_q[STG_W'(i)] <= vld_d[STG_W'(i)];
                ch_q[STG_W'(i)]  <= ch_d[STG_W'(i)];
                y_q[STG_W'(i)]   <= y_d[STG_W'(i)];
                ovf_q[STG_W'(i)] <= ovf_d[STG_W'(i)];
            end
            for (int unsigned c = 0; c < N_CH; c++) begin
                acc_q[CH_W'(c)] <= acc_d[CH_W'(c)];
            end
            sticky_q <= sticky_d;
        end
    end

endmodule
